pll_reset_ctrl: RTL

Sequencer on the consumer side of the PLL's rst/locked interface, clocked from the free-running board reference clock.
- Drives the PLL's active-high reset.
- Synchronises and debounces the PLL `locked` flag.
- Releases the downstream system reset only after lock has been stable for a programmable time.
- Re-sequences the PLL on lock loss, lock timeout or software request, and counts lock losses and timeouts for status.

---
 rtl/pll_rst_pkg.sv | 27 ++
 rtl/pll_reset_ctrl_sync2.sv | 24 ++
 rtl/pll_reset_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Optional status counters are enabled with PLL_RST_STATUS_EN.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        RUN
    } state_t;

    localparam int DEF_RST_CYCLES     = 16;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_TIMEOUT_CYCLES = 65536;
    localparam int DEF_CNT_W          = 8;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] max
    );
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset.
// Reset value is set by RST_VAL.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset / lock sequencer on the board reference clock.
// Define PLL_RST_STATUS_EN to build the loss/timeout counters.
module pll_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int RST_W = cnt_w(RST_CYCLES);
    localparam int STB_W = cnt_w(STABLE_CYCLES);
    localparam int TMO_W = cnt_w(TIMEOUT_CYCLES);

    localparam logic [RST_W-1:0] RST_LAST =
        RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST =
        STB_W'(STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [RST_W-1:0] rst_cnt;
    logic [STB_W-1:0] stb_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             locked_s;
    logic             rst_done;
    logic             lock_done;
    logic             tmo_hit;

    sync2 #(
        .RST_VAL(1'b0)
    ) u_lock_sync (
        .clk  (refclk),
        .rst_n(rst),
        .d    (pll_locked),
        .q    (locked_s)
    );

    assign rst_done  = (rst_cnt == RST_LAST);
    assign lock_done = locked_s && (stb_cnt == STB_LAST);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state   <= RESET_PLL;
            rst_cnt <= '0;
            stb_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            unique case (state)
                RESET_PLL: begin
                    if (relock_req) begin
                        rst_cnt <= '0;
                    end else if (rst_done) begin
                        rst_cnt <= '0;
                        state   <= WAIT_LOCK;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (relock_req || lock_done || tmo_hit) begin
                        stb_cnt <= '0;
                        tmo_cnt <= '0;
                        // Lock beats a same-cycle timeout.
                        if (!relock_req && lock_done)
                            state <= RUN;
                        else
                            state <= RESET_PLL;
                    end else begin
                        stb_cnt <= locked_s ?
                                   stb_cnt + STB_W'(1) : '0;
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                RUN: begin
                    if (relock_req || !locked_s)
                        state <= RESET_PLL;
                end
                default: state <= RESET_PLL;
            endcase
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
        end else begin
            pll_rst   <= (state == RESET_PLL);
            sys_rst_n <= (state == RUN);
            ready     <= (state == RUN);
        end
    end

`ifdef PLL_RST_STATUS_EN
    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    logic             loss_ev;
    logic             tmo_ev;
    logic [CNT_W-1:0] loss_q;
    logic [CNT_W-1:0] tmo_q;

    assign loss_ev = (state == RUN) && !locked_s;
    assign tmo_ev  = (state == WAIT_LOCK) && !relock_req &&
                     !lock_done && tmo_hit;

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            loss_q <= '0;
            tmo_q  <= '0;
        end else begin
            if (loss_ev)
                loss_q <= CNT_W'(sat_inc(32'(loss_q), CNT_MAX));
            if (tmo_ev)
                tmo_q <= CNT_W'(sat_inc(32'(tmo_q), CNT_MAX));
        end
    end

    assign loss_cnt    = loss_q;
    assign timeout_cnt = tmo_q;
`else
    assign loss_cnt    = '0;
    assign timeout_cnt = '0;
`endif

endmodule
